// File: rtl/seg7_readback_decoder.sv
// Seven-segment readback decoder: debounces {tens, ge, xiao}, decodes to tenths, classifies changes.
// Optional SEG_POINT_CHECK_EN folds the decimal point into the sampled word and drives prec.
module seg7_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_TENTHS    = 999
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  seg_ge,
  input  logic [6:0]  seg_xiao,
  input  logic [3:0]  tens,
  input  logic        point,
  output logic [11:0] val_bcd,
  output logic [9:0]  val_tenths,
  output logic        upd,
  output logic [1:0]  dir,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [7:0]  jump_cnt,
  output logic        prec
);

  localparam logic [7:0] SC   = 8'(STABLE_CYCLES);
  localparam logic [9:0] MAXV = 10'(MAX_TENTHS);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_TRACK} state_t;

`ifdef SEG_POINT_CHECK_EN
  localparam int WW = 19;
  logic [WW-1:0] word_in;
  assign word_in = {point, tens, seg_ge, seg_xiao};
`else
  localparam int WW = 18;
  logic [WW-1:0] word_in;
  logic          unused_point;
  assign word_in      = {tens, seg_ge, seg_xiao};
  assign unused_point = point;
`endif

  // {legal, digit}; codes are active-low a..g
  function automatic logic [4:0] seg_dec(input logic [6:0] c);
    case (c)
      7'b0000001: return {1'b1, 4'd0};
      7'b1001111: return {1'b1, 4'd1};
      7'b0010010: return {1'b1, 4'd2};
      7'b0000110: return {1'b1, 4'd3};
      7'b1001100: return {1'b1, 4'd4};
      7'b0100100: return {1'b1, 4'd5};
      7'b0100000: return {1'b1, 4'd6};
      7'b0001111: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0000100: return {1'b1, 4'd9};
      default:    return 5'd0;
    endcase
  endfunction

  state_t        state, state_n;
  logic [WW-1:0] smp;
  logic [7:0]    cnt, cnt_n;
  logic [11:0]   val_bcd_n;
  logic [9:0]    val_tenths_n;
  logic          upd_n, err_n, prec_n;
  logic [1:0]    dir_n;
  logic [7:0]    err_cnt_n, jump_cnt_n;

  logic [4:0]  dg, dx;
  logic [3:0]  s_tens;
  logic        s_point, legal, same_val, stable, is_up, is_dn;
  logic [9:0]  new_tenths;
  logic [10:0] old_w, new_w;

  assign dg     = seg_dec(smp[13:7]);
  assign dx     = seg_dec(smp[6:0]);
  assign s_tens = smp[17:14];
`ifdef SEG_POINT_CHECK_EN
  assign s_point = smp[18];
`else
  assign s_point = 1'b0;
`endif
  assign legal      = dg[4] & dx[4] & (s_tens <= 4'd9);
  assign new_tenths = 10'(s_tens) * 10'd100 + 10'(dg[3:0]) * 10'd10 + 10'(dx[3:0]);
  assign same_val   = ({s_tens, dg[3:0], dx[3:0]} == val_bcd) && (s_point == prec);
  assign old_w      = {1'b0, val_tenths};
  assign new_w      = {1'b0, new_tenths};
  assign is_up      = (new_w == old_w + 11'd1) || (val_tenths == MAXV && new_tenths == 10'd0);
  assign is_dn      = (new_w + 11'd1 == old_w) || (val_tenths == 10'd0 && new_tenths == MAXV);

  always_comb begin
    state_n      = state;
    val_bcd_n    = val_bcd;
    val_tenths_n = val_tenths;
    prec_n       = prec;
    dir_n        = dir;
    err_cnt_n    = err_cnt;
    jump_cnt_n   = jump_cnt;
    upd_n        = 1'b0;
    err_n        = 1'b0;

    // counter restarts on any new sample and is parked while disabled
    if (state == S_IDLE || !en)  cnt_n = 8'd0;
    else if (word_in != smp)     cnt_n = 8'd0;
    else if (cnt == SC)          cnt_n = cnt;
    else                         cnt_n = cnt + 8'd1;

    // fires once, on the edge the counter first reaches SC
    stable = (state != S_IDLE) && en && (cnt != SC) && (cnt_n == SC);

    case (state)
      S_IDLE: if (en) state_n = S_FIRST;
      default: begin
        if (!en) begin
          state_n = S_IDLE;
        end else if (stable) begin
          if (!legal) begin
            err_n = 1'b1;
            if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
          end else if (state == S_FIRST || !same_val) begin
            upd_n        = 1'b1;
            val_bcd_n    = {s_tens, dg[3:0], dx[3:0]};
            val_tenths_n = new_tenths;
            prec_n       = s_point;
            state_n      = S_TRACK;
            if (state == S_FIRST || new_tenths == val_tenths) dir_n = 2'b00;
            else if (is_up)                                   dir_n = 2'b01;
            else if (is_dn)                                   dir_n = 2'b10;
            else begin
              dir_n = 2'b11;
              if (jump_cnt != 8'hFF) jump_cnt_n = jump_cnt + 8'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      smp        <= '0;
      cnt        <= 8'd0;
      val_bcd    <= 12'd0;
      val_tenths <= 10'd0;
      prec       <= 1'b0;
      dir        <= 2'b00;
      err_cnt    <= 8'd0;
      jump_cnt   <= 8'd0;
      upd        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      smp        <= word_in;
      cnt        <= cnt_n;
      val_bcd    <= val_bcd_n;
      val_tenths <= val_tenths_n;
      prec       <= prec_n;
      dir        <= dir_n;
      err_cnt    <= err_cnt_n;
      jump_cnt   <= jump_cnt_n;
      upd        <= upd_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Bench for seg7_readback_decoder: directed vector table, counter saturation, and random
// stimulus against a history-based reference model.
module tb_seg7_readback_decoder;
  localparam int S    = 4;
  localparam int MAXT = 999;

  logic        clk_50M = 1'b0, rst_n = 1'b0, en = 1'b0, point = 1'b0;
  logic [6:0]  seg_ge = '0, seg_xiao = '0;
  logic [3:0]  tens = '0;
  logic [11:0] val_bcd;
  logic [9:0]  val_tenths;
  logic        upd, err, prec;
  logic [1:0]  dir;
  logic [7:0]  err_cnt, jump_cnt;

  always #10 clk_50M = ~clk_50M;

  seg7_readback_decoder #(.STABLE_CYCLES(S), .MAX_TENTHS(MAXT)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .en(en), .seg_ge(seg_ge), .seg_xiao(seg_xiao),
    .tens(tens), .point(point), .val_bcd(val_bcd), .val_tenths(val_tenths), .upd(upd),
    .dir(dir), .err(err), .err_cnt(err_cnt), .jump_cnt(jump_cnt), .prec(prec));

  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int nvec = 0, nbad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] wd(input int t, input int g, input int x, input bit p);
    return {p, 4'(t), codes[g], codes[x]};
  endfunction

  function automatic logic [18:0] eff(input logic [18:0] w);
`ifdef SEG_POINT_CHECK_EN
    return w;
`else
    return {1'b0, w[17:0]};
`endif
  endfunction

  // reference model: a word is accepted when the last S+1 edge samples agree and the one before differed
  logic [18:0] q[$];
  bit          m_idle = 1, m_have = 0, m_upd = 0, m_err = 0, m_prec = 0;
  int          m_val = 0, m_dir = 0, m_ec = 0, m_jc = 0;
  logic [11:0] m_bcd = '0;
  logic [18:0] m_word = '0;

  function automatic int digit(input logic [6:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [18:0] w, input logic e, input logic r);
    bit st;
    int t, g, x, nt, d;
    m_upd = 0; m_err = 0;
    if (r) begin
      m_idle = 1; m_have = 0; q.delete();
      m_val = 0; m_bcd = '0; m_prec = 0; m_dir = 0; m_ec = 0; m_jc = 0; m_word = '0;
      return;
    end
    if (!e) begin m_idle = 1; q.delete(); return; end
    if (m_idle) begin m_idle = 0; m_have = 0; q.delete(); q.push_back(w); return; end
    q.push_back(w);
    if (q.size() > S + 2) void'(q.pop_front());
    st = (q.size() >= S + 1);
    for (int i = 1; i <= S && st; i++) if (q[q.size() - 1 - i] != w) st = 0;
    if (st && q.size() > S + 1 && q[0] == w) st = 0;
    if (!st) return;
    t = int'(w[17:14]); g = digit(w[13:7]); x = digit(w[6:0]);
    if (t > 9 || g < 0 || x < 0) begin
      m_err = 1;
      if (m_ec < 255) m_ec++;
      return;
    end
    nt = t * 100 + g * 10 + x;
    if (!m_have || w != m_word) begin
      if (!m_have || nt == m_val) m_dir = 0;
      else begin
        d = (nt - m_val + MAXT + 1) % (MAXT + 1);
        if (d == 1) m_dir = 1;
        else if (d == MAXT) m_dir = 2;
        else begin m_dir = 3; if (m_jc < 255) m_jc++; end
      end
      m_have = 1; m_upd = 1; m_val = nt; m_bcd = {4'(t), 4'(g), 4'(x)};
      m_prec = w[18]; m_word = w;
    end
  endtask

  int n_upd, n_err, first_upd, cyc;

  task automatic cycle(input logic r, input logic e, input logic [18:0] w);
    rst_n = !r; en = e;
    {point, tens, seg_ge, seg_xiao} = w;
    @(posedge clk_50M);
    model_edge(eff(w), e, r);
    @(negedge clk_50M);
    cyc++;
    if (upd) begin n_upd++; if (first_upd < 0) first_upd = cyc; end
    if (err) n_err++;
    chk("upd", int'(upd), int'(m_upd));
    chk("err", int'(err), int'(m_err));
    chk("dir", int'(dir), m_dir);
    chk("val_tenths", int'(val_tenths), m_val);
    chk("val_bcd", int'(val_bcd), int'(m_bcd));
    chk("err_cnt", int'(err_cnt), m_ec);
    chk("jump_cnt", int'(jump_cnt), m_jc);
    chk("prec", int'(prec), int'(m_prec));
  endtask

  task automatic clr();
    n_upd = 0; n_err = 0; first_upd = -1; cyc = 0;
  endtask

  typedef struct {
    bit          en;
    logic [18:0] w;
    int hold, e_upd, e_err, e_val, e_dir, e_jc, e_ec, e_prec, e_lat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [18:0] w;
    int hold;
    bit r, e;
    tbl[0]  = '{1, wd(1,5,0,0),  8, 1,0,150,0,0,0,0, 5};
    tbl[1]  = '{1, wd(1,5,1,0), 10, 1,0,151,1,0,0,0,-1};
    tbl[2]  = '{1, wd(1,5,2,0), 10, 1,0,152,1,0,0,0,-1};
    tbl[3]  = '{1, wd(1,5,1,0), 10, 1,0,151,2,0,0,0,-1};
    tbl[4]  = '{1, wd(1,5,0,0), 10, 1,0,150,2,0,0,0,-1};
    tbl[5]  = '{1, wd(1,5,9,0),  2, 0,0,150,2,0,0,0,-1};
    tbl[6]  = '{1, wd(1,5,0,0), 10, 0,0,150,2,0,0,0,-1};
    tbl[7]  = '{1, {1'b0,4'd1,7'b1111111,codes[0]}, 10, 0,1,150,2,0,1,0,-1};
    tbl[8]  = '{1, wd(4,2,0,0), 10, 1,0,420,3,1,1,0,-1};
    tbl[9]  = '{1, wd(9,9,9,0), 10, 1,0,999,3,2,1,0,-1};
    tbl[10] = '{1, wd(0,0,0,0), 10, 1,0,  0,1,2,1,0,-1};
    tbl[11] = '{1, wd(10,0,0,0),10, 0,1,  0,1,2,2,0,-1};
    tbl[12] = '{1, wd(9,9,9,0), 10, 1,0,999,2,2,2,0,-1};
    tbl[13] = '{0, wd(5,5,5,0), 20, 0,0,999,2,2,2,0,-1};
    tbl[14] = '{1, wd(5,5,5,0), 12, 1,0,555,0,2,2,0, 5};
    tbl[15] = '{1, wd(5,5,6,0), 10, 1,0,556,1,2,2,0,-1};
`ifdef SEG_POINT_CHECK_EN
    tbl[16] = '{1, wd(5,5,6,1), 10, 1,0,556,0,2,2,1,-1};
`else
    tbl[16] = '{1, wd(5,5,6,1), 10, 0,0,556,1,2,2,0,-1};
`endif

    // reset state
    clr();
    cycle(1, 0, '0);
    cycle(1, 1, wd(1,5,0,0));

    foreach (tbl[i]) begin
      clr();
      for (int h = 0; h < tbl[i].hold; h++) cycle(0, tbl[i].en, tbl[i].w);
      chk($sformatf("row%0d upd_pulses", i), n_upd, tbl[i].e_upd);
      chk($sformatf("row%0d err_pulses", i), n_err, tbl[i].e_err);
      chk($sformatf("row%0d val", i), int'(val_tenths), tbl[i].e_val);
      chk($sformatf("row%0d dir", i), int'(dir), tbl[i].e_dir);
      chk($sformatf("row%0d jump_cnt", i), int'(jump_cnt), tbl[i].e_jc);
      chk($sformatf("row%0d err_cnt", i), int'(err_cnt), tbl[i].e_ec);
      chk($sformatf("row%0d prec", i), int'(prec), tbl[i].e_prec);
      if (tbl[i].e_lat >= 0) chk($sformatf("row%0d latency", i), first_upd, tbl[i].e_lat);
    end

    // saturation of both counters
    clr();
    for (int k = 0; k < 260; k++)
      for (int h = 0; h < 6; h++) cycle(0, 1, wd((k % 2) ? 11 : 12, 0, 0, 0));
    chk("err_cnt saturated", int'(err_cnt), 255);
    chk("err pulses in saturation run", n_err, 260);
    clr();
    for (int k = 0; k < 260; k++)
      for (int h = 0; h < 6; h++) cycle(0, 1, wd((k % 2) ? 5 : 1, 0, 0, 0));
    chk("jump_cnt saturated", int'(jump_cnt), 255);
    chk("upd pulses in jump run", n_upd, 260);

    // random words, holds, enable drops and mid-run resets
    for (int k = 0; k < 400; k++) begin
      int t, g, x;
      t = $urandom_range(0, 10);
      g = $urandom_range(0, 10);
      x = $urandom_range(0, 10);
      w = {1'($urandom_range(0, 4) == 0), 4'(t),
           (g == 10) ? 7'($urandom) : codes[g],
           (x == 10) ? 7'($urandom) : codes[x]};
      hold = $urandom_range(1, 8);
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 19) != 0);
      for (int h = 0; h < hold; h++) cycle(r && h == 0, e, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/seg7_readback_decoder.md
Name: seg7_readback_decoder

Overview:
- Receiving end of the timer display interface: samples the seven-segment digit codes (ge, xiao) and BCD tens that the timer drives, and decodes them back to a numeric value in tenths of a second.
- Filters glitches and accepts a value only after it has been stable.
- Classifies each accepted change as count-up, count-down or jump, and flags illegal segment codes.
- Used as an on-chip self-check and as a numeric readout source for the stopwatch/countdown system.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical samples required before a value is accepted (legal range 1..255).
- MAX_TENTHS, 999: wrap point for up/down classification, in tenths.

Ports:
- clk_50M  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  monitor enable.
- seg_ge  in  7  ones-digit segment code, bit6=a … bit0=g, active-low.
- seg_xiao  in  7  tenths-digit segment code, same encoding.
- tens  in  4  tens digit, BCD.
- point  in  1  decimal-point/precision indicator from the timer.
- val_bcd  out  12  accepted value {tens, ge, xiao}.
- val_tenths  out  10  accepted value in binary, = tens*100 + ge*10 + xiao.
- upd  out  1  one-cycle pulse when a new value is accepted.
- dir  out  2  change class of the last update: 00 none, 01 up, 10 down, 11 jump.
- err  out  1  one-cycle pulse when an illegal word is accepted.
- err_cnt  out  8  saturating count of illegal-word acceptances.
- jump_cnt  out  8  saturating count of dir=11 updates.
- prec  out  1  accepted point value (tied 0 without the optional feature).

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0, state S_IDLE, stability counter 0, sample registers 0.
- Digit decode table (code -> digit):
  - 0000001 -> 0, 1001111 -> 1, 0010010 -> 2, 0000110 -> 3, 1001100 -> 4
  - 0100100 -> 5, 0100000 -> 6, 0001111 -> 7, 0000000 -> 8, 0000100 -> 9
  - Any other code is illegal. tens > 9 is illegal.
- Input word {tens, seg_ge, seg_xiao} is registered once (sample register).
  - Stability counter resets to 0 whenever the sample differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES.
  - A word is "stable" in the cycle its counter reaches STABLE_CYCLES.
- Latency: new input held from cycle t -> upd/err asserted in cycle t+STABLE_CYCLES+1, with outputs updated in that same cycle.
- FSM states:
  - S_IDLE: en=0. Outputs hold their last values; the stability counter is held at 0. en=1 -> S_FIRST.
  - S_FIRST: on the first stable legal word, load val_*, pulse upd, set dir=00, go to S_TRACK.
  - S_TRACK: on a stable legal word different from the accepted value, load val_*, pulse upd, and classify:
    - new == old+1, or old == MAX_TENTHS and new == 0 -> 01
    - new == old−1, or old == 0 and new == MAX_TENTHS -> 10
    - otherwise -> 11, and jump_cnt increments
  - S_TRACK: a stable word equal to the accepted value produces no pulse.
  - en=0 in any state -> S_IDLE next cycle. A re-enable never classifies across the gap because it passes through S_FIRST.
- Illegal stable word (any state except S_IDLE):
  - err pulses once per stable occurrence; err_cnt increments; val_*, dir and state are unchanged.
  - A further pulse requires the input to change and restabilise.
- Counters saturate at 255 with no wrap.
- upd and err are never high together.
- Reset mid-operation (rst_n low in any state) -> full reset values on the next edge, taking priority over en.

Optional Feature:
- Macro SEG_POINT_CHECK_EN.
- Defined:
  - point is part of the sampled word and the stability compare.
  - An accepted change in point loads prec.
  - A point-only change pulses upd with dir=00 and does not alter val_* or jump_cnt.
- Undefined: point is ignored; prec is constant 0; a point toggle never causes upd.

Test Plan:
- Reset, then en=1, tens=1, ge=0100100, xiao=0000001 held -> upd exactly once at hold+5 cycles, val_tenths=150, val_bcd=0x150, dir=00.
- Step 150 -> 151 -> 152, each held 10 cycles -> two upd pulses, dir=01 each time, jump_cnt=0. Step 152 -> 151 -> dir=10.
- Glitch: xiao toggles to 9 for 2 cycles then back to 1 -> no upd, no err, val_tenths unchanged.
- Illegal code seg_ge=1111111 held 10 cycles -> single err pulse, err_cnt=1, val unchanged. Then 150 -> 420 -> upd, dir=11, jump_cnt=1.
- Wrap: 999 then 000 -> dir=01. en=0 for 20 cycles with input 555, then en=1 -> first upd has dir=00 and val_tenths=555.
- With SEG_POINT_CHECK_EN: point 0 -> 1 at constant value -> upd, dir=00, prec=1. Without the macro -> no upd and prec=0.
